// File: rtl/or_scan_if.sv
// Bundle of the or_scan_ctrl request/frame signals; the master side drives start
// and the operand bits, the slave side (the sequencer) returns status and LEDs.
interface or_scan_if #(
    parameter int PAIRS = 7
);
    logic                 start;
    logic [2*PAIRS-1:0]   in;
    logic                 busy;
    logic                 done;
    logic [2:0]           pair_idx;
    logic [7:0]           o_led;

    modport master (output start, in, input busy, done, pair_idx, o_led);
    modport slave  (input start, in, output busy, done, pair_idx, o_led);
endinterface

// File: rtl/or_scan_ctrl.sv
// Time-multiplexed pairwise-OR sequencer: one shared OR unit walks the captured
// operand pairs and publishes the whole frame at once. Macro OR_SCAN_CONTINUOUS_EN: rescan forever.
module or_scan_ctrl #(
    parameter int PAIRS       = 7,
    parameter int STEP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    or_scan_if.slave   bus,
    output logic [1:0] state_dbg
);

    // Handshake: start is a level request sampled only in IDLE (ignored, not
    // queued, elsewhere); done pulses for one cycle together with the new o_led.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SCAN    = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] STEP_LAST = 4'(STEP_CYCLES - 1);
    localparam logic [2:0] IDX_LAST  = 3'(PAIRS - 1);

    state_t             state;
    state_t             state_nxt;
    logic [2*PAIRS-1:0] snap;
    logic [PAIRS-1:0]   work;
    logic [PAIRS-1:0]   work_nxt;
    logic [2:0]         idx;
    logic [3:0]         step;
    logic [6:0]         frame;
    logic               frame_valid;
    logic               pair_or;
    logic               step_last;
    logic               pair_last;

    assign step_last = (step == STEP_LAST);
    assign pair_last = (idx == IDX_LAST);

    // Shared OR unit plus the working register with the current pair merged in.
    always_comb begin
        pair_or  = 1'b0;
        work_nxt = work;
        for (int k = 0; k < PAIRS; k++) begin
            if (idx == 3'(k)) begin
                pair_or = snap[2*k] | snap[2*k+1];
            end
        end
        for (int k = 0; k < PAIRS; k++) begin
            if (idx == 3'(k)) begin
                work_nxt[k] = pair_or;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CAPTURE;
            CAPTURE: state_nxt = SCAN;
            SCAN:    if (step_last && pair_last) state_nxt = DONE;
`ifdef OR_SCAN_CONTINUOUS_EN
            DONE:    state_nxt = CAPTURE;
`else
            DONE:    state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap        <= '0;
            work        <= '0;
            idx         <= '0;
            step        <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
        end else begin
            case (state)
                CAPTURE: begin
                    snap <= bus.in;
                    work <= '0;
                    idx  <= '0;
                    step <= '0;
                end
                SCAN: begin
                    if (step_last) begin
                        work <= work_nxt;
                        // The last pair goes straight into the published frame so
                        // the LEDs change in one step on entry to DONE.
                        if (pair_last) begin
                            frame       <= 7'(work_nxt);
                            frame_valid <= 1'b1;
                        end else begin
                            idx  <= idx + 3'd1;
                            step <= '0;
                        end
                    end else begin
                        step <= step + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state == CAPTURE) || (state == SCAN);
    assign bus.done     = (state == DONE);
    assign bus.pair_idx = (state == SCAN) ? idx : 3'd0;
    assign bus.o_led    = {frame_valid, frame};
    assign state_dbg    = state;

endmodule

// File: doc/or_scan_ctrl.md
# or_scan_ctrl

Sequencer for the pairwise-OR LED datapath. Instead of seven parallel 2-input ORs, one shared OR unit is time-multiplexed across the 14 input bits. The block captures a snapshot of `in` on a start request and steps through the pairs one at a time. It assembles the results in a working register and publishes the complete frame to the LEDs atomically. `o_led[7]`, unused in the combinational version, becomes a frame-valid indicator.

## Interface
Parameters:
- `PAIRS`, 7: number of input pairs; input width is 2*PAIRS; legal range 1..7.
- `STEP_CYCLES`, 1: clock cycles spent on each pair; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  scan request; sampled only in IDLE.
- `in`  in  2*PAIRS  operand bits; pair k is `in[2k+1:2k]`.
- `busy`  out  1  high in CAPTURE and SCAN.
- `done`  out  1  one-cycle pulse; high only in DONE.
- `pair_idx`  out  3  index of the pair currently being processed; 0 outside SCAN.
- `o_led`  out  8  bits [PAIRS-1:0] hold the published frame; bit 7 holds frame-valid; unused bits are 0.

## Operation
- State machine has four states: IDLE, CAPTURE, SCAN, DONE.
- **IDLE:** on `start`=1, go to CAPTURE. Otherwise stay in IDLE.
- **CAPTURE:** latch `in` into a snapshot register. Clear the working register. Set `pair_idx`=0 and the step counter to 0. Go to SCAN.
- **SCAN:** the shared unit computes snap[2·idx] | snap[2·idx+1].
  - On the last cycle of a step (step counter = STEP_CYCLES-1), write the result into working bit idx.
  - If idx = PAIRS-1, go to DONE. Otherwise increment idx and clear the step counter.
- **DONE:** `o_led[PAIRS-1:0]` is loaded from the working register on entry to DONE. `o_led[7]` is set on that same entry. Go to IDLE next cycle (see Configuration).
- `in` changing after CAPTURE has no effect on the current frame.
- `start` in CAPTURE, SCAN or DONE is ignored and not queued.
- `o_led` holds its previous frame throughout a scan. A partial frame is never visible.
- Once set, `o_led[7]` stays 1 until reset.
- Counters never wrap within a frame. `pair_idx` returns to 0 only via CAPTURE or leaving SCAN.

## Timing
- Start accepted in IDLE at edge T. CAPTURE occupies cycle T+1. SCAN occupies T+2 through T+1+PAIRS·STEP_CYCLES. DONE occurs at T+2+PAIRS·STEP_CYCLES.
- New `o_led` appears together with `done`=1.
- Default parameters give 9 cycles from the start edge to `done`.
- Back-to-back operation: with `start` held high, a new CAPTURE begins 2 cycles after DONE (DONE→IDLE→CAPTURE). The period is PAIRS·STEP_CYCLES+3 cycles.
- Reset values: state IDLE; `busy`=0, `done`=0, `pair_idx`=0, `o_led`=8'h00; snapshot and working registers 0.
- Reset asserted mid-scan: outputs take their reset values immediately (asynchronous). The frame is discarded. After release, the block waits in IDLE for `start`.
- All outputs are registered or decoded from registered state only. There is no combinational path from `in` or `start` to outputs.

## Configuration
- Macro: `OR_SCAN_CONTINUOUS_EN`.
- **Undefined:** DONE→IDLE. Each frame requires a `start`.
- **Defined:** DONE→CAPTURE. After the first accepted `start`, the block rescans indefinitely with period PAIRS·STEP_CYCLES+2 and ignores `start`. `busy` is low only in DONE. Only `rst` returns the block to IDLE.

## Test plan
- Reset then idle, no start: `o_led`=8'h00, `busy`=0, `done`=0 for 20 cycles.
- Defaults, `in`=14'h1387, start pulsed at T:
  - `busy` high T+1..T+8; `pair_idx` steps 0..6 over T+2..T+8.
  - `done` at T+9 with `o_led`=8'hDB.
  - `o_led` stays 8'h00 before T+9.
- `in`=14'h3FFF captured, then `in` driven to 14'h0000 during SCAN: frame still 8'hFF at `done`.
- STEP_CYCLES=3, `in`=14'h0001, start at T: `done` at T+23, `o_led`=8'h81; `start` pulses during busy produce no extra frame.
- Assert `rst` at T+5 of a scan: `busy`/`o_led`/`pair_idx` go 0 at once; no `done` follows; a fresh start with `in`=14'h2000 yields `o_led`=8'hC0.
- `OR_SCAN_CONTINUOUS_EN` defined, one start pulse: `done` pulses every 9 cycles. Changing `in` to 14'h0003 between frames gives `o_led`=8'h81 on the next frame.
